// File: rtl/id_fetch_ctrl_pkg.sv
// Shared definitions for the ID-side fetch controller: opcode/function codes,
// controller state encodings, the NOP word and the instruction decode helper.
package id_fetch_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL = 6'h00;
  localparam logic [5:0] FUNC_SRL = 6'h02;
  localparam logic [5:0] FUNC_SRA = 6'h03;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_XOR = 6'h26;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic uses_rs;
    logic uses_rt;
    logic is_beq;
    logic is_bne;
    logic is_j;
  } dec_t;

  // Operand usage and control-flow class of one instruction word.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = '0;
    case (inst[31:26])
      OP_RTYPE: begin
        d.uses_rt = 1'b1;
        // Shifts take their source from rt and the shamt field only.
        d.uses_rs = !(inst[5:0] == FUNC_SLL || inst[5:0] == FUNC_SRL ||
                      inst[5:0] == FUNC_SRA);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: d.uses_rs = 1'b1;
      OP_SW: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        d.is_beq  = 1'b1;
      end
      OP_BNE: begin
        d.uses_rs = 1'b1;
        d.uses_rt = 1'b1;
        d.is_bne  = 1'b1;
      end
      OP_J:    d.is_j = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_fetch_ctrl_hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
module id_hazard_detect
  import id_fetch_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic       is_branch,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_mem_read,
  output logic       load_haz,
  output logic       br_haz
);

  // Register $0 never carries a dependency.
  always_comb begin
    load_haz = ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs && ex_rd == rs) || (uses_rt && ex_rd == rt));
    // Branches compare in ID, so any pending EX result or MEM load blocks them.
    br_haz = is_branch &&
             ((ex_reg_write && (ex_rd != 5'd0) && (ex_rd == rs || ex_rd == rt)) ||
              (mem_mem_read && (mem_rd != 5'd0) && (mem_rd == rs || mem_rd == rt)));
  end

endmodule

// File: rtl/id_fetch_ctrl.sv
// ID-side fetch controller: IF/ID register, hazard stalls and branch/jump
// resolution in ID. Optional macro ID_FETCH_PERF_CNT_EN adds stall/flush
// cycle counters.
module id_fetch_ctrl
  import id_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_inst,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        mem_mem_read,
  output logic [31:0] npc,
  output logic [31:0] nid_pc,
  output logic        ctrl_branch,
  output logic        id_wpcir,
  output logic        jmp_stall,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        id_bubble
`ifdef ID_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  logic [1:0]  state_q, state_d;
  dec_t        dec;
  logic        load_haz, br_haz, hazard, taken;
  logic [31:0] br_target, j_target;

  // Decode the latched instruction; an invalid slot decodes to nothing.
  always_comb begin
    dec = decode(id_inst);
    if (!id_valid) dec = '0;
  end

  id_hazard_detect u_hazard (
    .rs           (id_inst[25:21]),
    .rt           (id_inst[20:16]),
    .uses_rs      (dec.uses_rs),
    .uses_rt      (dec.uses_rt),
    .is_branch    (dec.is_beq | dec.is_bne),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_mem_read (mem_mem_read),
    .load_haz     (load_haz),
    .br_haz       (br_haz)
  );

  // Resolve branch/jump; a hazard always wins so stale operands never decide.
  always_comb begin
    hazard    = load_haz | br_haz;
    br_target = id_pc4 + {{16{id_inst[15]}}, id_inst[15:0]};
    j_target  = {id_pc4[31:26], id_inst[25:0]};
    nid_pc    = dec.is_j ? j_target : br_target;
    taken     = 1'b0;
    if (!hazard) begin
      taken = dec.is_j || (dec.is_beq && rs_data == rt_data) ||
              (dec.is_bne && rs_data != rt_data);
    end
  end

  // IF control outputs and next controller state.
  always_comb begin
    npc         = if_pc4;
    ctrl_branch = 1'b0;
    id_wpcir    = 1'b0;
    jmp_stall   = 1'b0;
    id_bubble   = 1'b0;
    state_d     = ST_RUN;
    if (!rst) begin
      npc       = RESET_PC;
      id_bubble = 1'b1;
      state_d   = ST_BOOT;
    end else begin
      case (state_q)
        // IF/ID is empty in BOOT, so no hazard or branch can exist yet.
        ST_BOOT: state_d = ST_RUN;
        default: begin
          if (hazard) begin
            id_wpcir  = 1'b1;
            id_bubble = 1'b1;
            npc       = if_pc4 - 32'd1;
            state_d   = ST_STALL;
          end else if (taken) begin
            ctrl_branch = 1'b1;
            jmp_stall   = 1'b1;
            npc         = nid_pc;
            state_d     = ST_FLUSH;
          end
        end
      endcase
    end
  end

  // State and IF/ID register: hold on stall, squash on taken branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      id_inst  <= NOP_INST;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!id_wpcir) begin
        id_pc4 <= if_pc4;
        if (jmp_stall) begin
          id_inst  <= NOP_INST;
          id_valid <= 1'b0;
        end else begin
          id_inst  <= if_inst;
          id_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ID_FETCH_PERF_CNT_EN
  // Saturating stall/flush cycle counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (id_wpcir && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (jmp_stall && flush_cycles != 32'hFFFF_FFFF) flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_fetch_ctrl.sv
// Scoreboard bench for id_fetch_ctrl: each cycle's expected outputs are queued
// with the stimulus and compared on the following falling edge.
module tb_id_fetch_ctrl;

  localparam logic [31:0] I_ORI1 = 32'h3405_0001;  // ori $5,$0,1
  localparam logic [31:0] I_ORI2 = 32'h3406_0002;  // ori $6,$0,2
  localparam logic [31:0] I_ADD  = 32'h0044_1820;  // add $3,$2,$4
  localparam logic [31:0] I_BEQ  = 32'h1022_FFFC;  // beq $1,$2,-4
  localparam logic [31:0] I_BNE  = 32'h1420_0003;  // bne $1,$0,3
  localparam logic [31:0] I_J    = 32'h0800_0020;  // j 0x20

  localparam logic [31:0] S_BOOT = 32'd0, S_RUN = 32'd1, S_STALL = 32'd2, S_FLUSH = 32'd3;

  localparam int SEL_NPC = 0, SEL_NID = 1, SEL_BR = 2, SEL_WPC = 3, SEL_JS = 4;
  localparam int SEL_BUB = 5, SEL_VAL = 6, SEL_INST = 7, SEL_PC4 = 8, SEL_ST = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc4, if_inst, rs_data, rt_data;
  logic [4:0]  ex_rd, mem_rd;
  logic        ex_reg_write, ex_mem_read, mem_mem_read;
  logic [31:0] npc, nid_pc, id_inst, id_pc4;
  logic        ctrl_branch, id_wpcir, jmp_stall, id_valid, id_bubble;
`ifdef ID_FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  id_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc4       (if_pc4),
    .if_inst      (if_inst),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_mem_read (mem_mem_read),
    .npc          (npc),
    .nid_pc       (nid_pc),
    .ctrl_branch  (ctrl_branch),
    .id_wpcir     (id_wpcir),
    .jmp_stall    (jmp_stall),
    .id_inst      (id_inst),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid),
    .id_bubble    (id_bubble)
`ifdef ID_FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_NPC:  return npc;
      SEL_NID:  return nid_pc;
      SEL_BR:   return {31'd0, ctrl_branch};
      SEL_WPC:  return {31'd0, id_wpcir};
      SEL_JS:   return {31'd0, jmp_stall};
      SEL_BUB:  return {31'd0, id_bubble};
      SEL_VAL:  return {31'd0, id_valid};
      SEL_INST: return id_inst;
      SEL_PC4:  return id_pc4;
      default:  return {30'd0, dut.state_q};
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
  endtask

  // Compare everything queued for this cycle, then advance past the next edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc4);
    if_inst = inst;
    if_pc4  = pc4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rs_data = '0; rt_data = '0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = '0; mem_mem_read = 1'b0;
    fetch(I_ORI1, 32'h5);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      expect_sig("rst_npc", SEL_NPC, 32'h0);
      expect_sig("rst_br", SEL_BR, 32'd0);
      expect_sig("rst_wpcir", SEL_WPC, 32'd0);
      expect_sig("rst_jstall", SEL_JS, 32'd0);
      expect_sig("rst_bubble", SEL_BUB, 32'd1);
      if (i > 0) begin
        expect_sig("rst_state", SEL_ST, S_BOOT);
        expect_sig("rst_valid", SEL_VAL, 32'd0);
      end
      cycle();
    end

    // BOOT cycle.
    rst = 1'b1;
    fetch(I_ORI1, 32'h1);
    expect_sig("boot_state", SEL_ST, S_BOOT);
    expect_sig("boot_valid", SEL_VAL, 32'd0);
    expect_sig("boot_npc", SEL_NPC, 32'h1);
    expect_sig("boot_bubble", SEL_BUB, 32'd0);
    cycle();

    // First RUN cycle; lw to $0 in EX is not a dependency.
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    fetch(I_ADD, 32'h2);
    expect_sig("run_state", SEL_ST, S_RUN);
    expect_sig("run_valid", SEL_VAL, 32'd1);
    expect_sig("run_inst", SEL_INST, I_ORI1);
    expect_sig("run_pc4", SEL_PC4, 32'h1);
    expect_sig("run_r0_wpcir", SEL_WPC, 32'd0);
    expect_sig("run_npc", SEL_NPC, 32'h2);
    cycle();

    // Load-use: lw $2 in EX, add $3,$2,$4 in ID.
    ex_mem_read = 1'b1; ex_rd = 5'd2; ex_reg_write = 1'b1;
    fetch(I_ORI2, 32'h3);
    expect_sig("lu_inst", SEL_INST, I_ADD);
    expect_sig("lu_wpcir", SEL_WPC, 32'd1);
    expect_sig("lu_bubble", SEL_BUB, 32'd1);
    expect_sig("lu_npc", SEL_NPC, 32'h2);
    expect_sig("lu_br", SEL_BR, 32'd0);
    cycle();

    // lw moved to MEM: a non-branch does not wait on it.
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_reg_write = 1'b0;
    mem_mem_read = 1'b1; mem_rd = 5'd2;
    expect_sig("lu2_state", SEL_ST, S_STALL);
    expect_sig("lu2_inst", SEL_INST, I_ADD);
    expect_sig("lu2_wpcir", SEL_WPC, 32'd0);
    expect_sig("lu2_bubble", SEL_BUB, 32'd0);
    expect_sig("lu2_npc", SEL_NPC, 32'h3);
    cycle();

    mem_mem_read = 1'b0; mem_rd = 5'd0;
    fetch(I_BEQ, 32'h10);
    expect_sig("post_lu_state", SEL_ST, S_RUN);
    expect_sig("post_lu_inst", SEL_INST, I_ORI2);
    cycle();

    // Taken beq: id_pc4=0x10, imm=-4.
    rs_data = 32'd5; rt_data = 32'd5;
    fetch(I_ORI1, 32'h11);
    expect_sig("beq_inst", SEL_INST, I_BEQ);
    expect_sig("beq_nid", SEL_NID, 32'h0C);
    expect_sig("beq_br", SEL_BR, 32'd1);
    expect_sig("beq_jstall", SEL_JS, 32'd1);
    expect_sig("beq_npc", SEL_NPC, 32'h0C);
    expect_sig("beq_wpcir", SEL_WPC, 32'd0);
    cycle();

    fetch(I_BNE, 32'h20);
    expect_sig("flush_state", SEL_ST, S_FLUSH);
    expect_sig("flush_valid", SEL_VAL, 32'd0);
    expect_sig("flush_inst", SEL_INST, 32'h0);
    expect_sig("flush_br", SEL_BR, 32'd0);
    expect_sig("flush_jstall", SEL_JS, 32'd0);
    expect_sig("flush_npc", SEL_NPC, 32'h20);
    cycle();

    // bne $1,$0 with $1 produced in EX, then loaded in MEM.
    rs_data = 32'd0; rt_data = 32'd0;
    ex_reg_write = 1'b1; ex_rd = 5'd1;
    fetch(I_ORI1, 32'h21);
    expect_sig("bne1_state", SEL_ST, S_RUN);
    expect_sig("bne1_inst", SEL_INST, I_BNE);
    expect_sig("bne1_wpcir", SEL_WPC, 32'd1);
    expect_sig("bne1_bubble", SEL_BUB, 32'd1);
    expect_sig("bne1_br", SEL_BR, 32'd0);
    expect_sig("bne1_npc", SEL_NPC, 32'h20);
    cycle();

    ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd1;
    expect_sig("bne2_state", SEL_ST, S_STALL);
    expect_sig("bne2_wpcir", SEL_WPC, 32'd1);
    expect_sig("bne2_br", SEL_BR, 32'd0);
    expect_sig("bne2_inst", SEL_INST, I_BNE);
    cycle();

    mem_mem_read = 1'b0; mem_rd = 5'd0;
    rs_data = 32'd7; rt_data = 32'd0;
    expect_sig("bne3_state", SEL_ST, S_STALL);
    expect_sig("bne3_wpcir", SEL_WPC, 32'd0);
    expect_sig("bne3_br", SEL_BR, 32'd1);
    expect_sig("bne3_jstall", SEL_JS, 32'd1);
    expect_sig("bne3_nid", SEL_NID, 32'h23);
    expect_sig("bne3_npc", SEL_NPC, 32'h23);
    cycle();

    fetch(I_BEQ, 32'h30);
    expect_sig("bne_flush_state", SEL_ST, S_FLUSH);
    expect_sig("bne_flush_valid", SEL_VAL, 32'd0);
    cycle();

    // Not-taken beq.
    rs_data = 32'd5; rt_data = 32'd6;
    fetch(I_J, 32'h0400_0001);
    expect_sig("beqnt_inst", SEL_INST, I_BEQ);
    expect_sig("beqnt_pc4", SEL_PC4, 32'h30);
    expect_sig("beqnt_br", SEL_BR, 32'd0);
    expect_sig("beqnt_jstall", SEL_JS, 32'd0);
    expect_sig("beqnt_nid", SEL_NID, 32'h2C);
    expect_sig("beqnt_npc", SEL_NPC, 32'h0400_0001);
    cycle();

    // Jump with a second j behind it in IF.
    fetch(I_J, 32'h0400_0002);
    expect_sig("j_inst", SEL_INST, I_J);
    expect_sig("j_nid", SEL_NID, 32'h0400_0020);
    expect_sig("j_br", SEL_BR, 32'd1);
    expect_sig("j_jstall", SEL_JS, 32'd1);
    expect_sig("j_npc", SEL_NPC, 32'h0400_0020);
    cycle();

    fetch(I_ADD, 32'h21);
    expect_sig("j_sq_inst", SEL_INST, 32'h0);
    expect_sig("j_sq_valid", SEL_VAL, 32'd0);
    expect_sig("j_sq_state", SEL_ST, S_FLUSH);
    cycle();

    // Load-use through rt ($4), then reset while stalled.
    ex_mem_read = 1'b1; ex_rd = 5'd4;
    fetch(I_ORI1, 32'h22);
    expect_sig("lurt_inst", SEL_INST, I_ADD);
    expect_sig("lurt_wpcir", SEL_WPC, 32'd1);
    expect_sig("lurt_state", SEL_ST, S_RUN);
    cycle();

    rst = 1'b0;
    expect_sig("rststall_state", SEL_ST, S_STALL);
    expect_sig("rststall_wpcir", SEL_WPC, 32'd0);
    expect_sig("rststall_npc", SEL_NPC, 32'h0);
    expect_sig("rststall_bubble", SEL_BUB, 32'd1);
    cycle();

    rst = 1'b1;
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    expect_sig("postrst_state", SEL_ST, S_BOOT);
    expect_sig("postrst_valid", SEL_VAL, 32'd0);
    expect_sig("postrst_inst", SEL_INST, 32'h0);
    expect_sig("postrst_pc4", SEL_PC4, 32'h0);
`ifdef ID_FETCH_PERF_CNT_EN
    check_eq("postrst_stall_cnt", stall_cycles, 32'd0);
    check_eq("postrst_flush_cnt", flush_cycles, 32'd0);
`endif
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
